// File: rtl/combo_ctrl_pkg.sv
// Shared types and constants for the combination-lock front-end controller.
package combo_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_ENTRY    = 3'd1,
      ST_CHECK    = 3'd2,
      ST_UNLOCKED = 3'd3,
      ST_CLEAR    = 3'd4,
      ST_LOCKOUT  = 3'd5
   } state_t;

   localparam int STAT_UNLOCK = 4;
   localparam int STAT_FAIL   = 3;

   localparam logic [3:0] NO_KEY = 4'h0;

   function automatic int max4(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

endpackage

// File: rtl/combo_ctrl_rr_arb.sv
// Two-way round-robin arbiter: on a tie the requester not granted last wins.
import combo_ctrl_pkg::*;

module combo_ctrl_rr_arb (
   input  logic       CLK,
   input  logic       RST,
   input  logic [1:0] req,
   input  logic       enable,
   input  logic       advance,
   output logic [1:0] gnt,
   output logic       gnt_id
);

   logic pri_b;

   always_comb begin
      gnt_id = (req == 2'b11) ? pri_b : req[1];
      gnt    = 2'b00;
      if (enable && (req != 2'b00)) gnt = gnt_id ? 2'b10 : 2'b01;
   end

   // NOTE: sequential state is written with <= only, so every register samples pre-edge values.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST)         pri_b <= 1'b0;
      else if (advance) pri_b <= ~gnt_id;
   end

endmodule

// File: rtl/combo_lock_ctrl.sv
// Front-end controller for the combination-lock core: arbitration, digit sequencing,
// verdict handling and failure lockout (lockout enabled by COMBO_CTRL_LOCKOUT_EN).
import combo_ctrl_pkg::*;

module combo_lock_ctrl #(
   parameter int CODE_LEN       = 4,
   parameter int MAX_FAILS      = 3,
   parameter int LOCKOUT_CYCLES = 1000,
   parameter int CHECK_WAIT     = 2,
   parameter int UNLOCK_CYCLES  = 8
) (
   input  logic                             CLK,
   input  logic                             RST,
   input  logic                             a_valid,
   output logic                             a_ready,
   input  logic [3:0]                       a_digit,
   input  logic                             b_valid,
   output logic                             b_ready,
   input  logic [3:0]                       b_digit,
   output logic [3:0]                       core_code,
   output logic                             core_rst,
   output logic                             core_master_rst,
   input  logic [4:0]                       core_status,
   output logic                             unlocked,
   output logic                             lockout,
   output logic                             owner,
   output logic [$clog2(MAX_FAILS+1)-1:0]   fail_cnt
);

   localparam int FW      = $clog2(MAX_FAILS + 1);
   localparam int CNT_MAX = max4(CODE_LEN, CHECK_WAIT, UNLOCK_CYCLES, LOCKOUT_CYCLES);
   localparam int TW      = $clog2(CNT_MAX + 1);

   localparam logic [TW-1:0] DIGIT_LAST  = TW'(CODE_LEN - 1);
   localparam logic [TW-1:0] CHECK_LAST  = TW'(CHECK_WAIT - 1);
   localparam logic [TW-1:0] UNLOCK_LAST = TW'(UNLOCK_CYCLES - 1);
   localparam logic [FW-1:0] FAIL_MAX    = FW'(MAX_FAILS);
`ifdef COMBO_CTRL_LOCKOUT_EN
   localparam logic [TW-1:0] LOCK_LAST   = TW'(LOCKOUT_CYCLES - 1);
`endif

   state_t          state, state_n;
   logic [TW-1:0]   cnt, cnt_n;
   logic [FW-1:0]   fail_n, fail_inc;
   logic            owner_n, acc_q, acc_n;
   logic [3:0]      code_n, digit;
   logic [1:0]      gnt;
   logic            gnt_id, sel_b, entry_rdy, take;
   logic            unused_status;

   assign unused_status = ^core_status[2:0];

   combo_ctrl_rr_arb u_arb (
      .CLK     (CLK),
      .RST     (RST),
      .req     ({b_valid, a_valid}),
      .enable  (state == ST_IDLE),
      .advance ((state == ST_IDLE) && take),
      .gnt     (gnt),
      .gnt_id  (gnt_id)
   );

   // The cycle after an acceptance is always a bubble, capping the rate at one digit per 2 cycles.
   assign entry_rdy = (state == ST_ENTRY) && !acc_q;
   assign a_ready   = (state == ST_IDLE) ? gnt[0] : (entry_rdy && !owner);
   assign b_ready   = (state == ST_IDLE) ? gnt[1] : (entry_rdy &&  owner);
   assign sel_b     = (state == ST_IDLE) ? gnt_id : owner;
   assign digit     = sel_b ? b_digit : a_digit;
   assign take      = (a_valid && a_ready) || (b_valid && b_ready);
   assign fail_inc  = (fail_cnt == FAIL_MAX) ? fail_cnt : fail_cnt + 1'b1;

   // NOTE: every variable gets a default before the case so no path infers a latch.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      fail_n  = fail_cnt;
      owner_n = owner;
      code_n  = NO_KEY;
      acc_n   = 1'b0;
      case (state)
         ST_IDLE, ST_ENTRY: begin
            if (take) begin
               code_n  = digit;
               acc_n   = 1'b1;
               owner_n = sel_b;
               cnt_n   = cnt + 1'b1;
               state_n = ST_ENTRY;
               if (digit == NO_KEY) begin
                  state_n = ST_CLEAR;
                  cnt_n   = '0;
                  fail_n  = fail_inc;
               end else if (cnt == DIGIT_LAST) begin
                  state_n = ST_CHECK;
                  cnt_n   = '0;
               end
            end
         end
         ST_CHECK: begin
            if (core_status[STAT_UNLOCK]) begin
               state_n = ST_UNLOCKED;
               cnt_n   = '0;
               fail_n  = '0;
            end else if (core_status[STAT_FAIL] || (cnt == CHECK_LAST)) begin
               state_n = ST_CLEAR;
               cnt_n   = '0;
               fail_n  = fail_inc;
            end else begin
               cnt_n   = cnt + 1'b1;
            end
         end
         ST_UNLOCKED: begin
            if (cnt == UNLOCK_LAST) begin
               state_n = ST_CLEAR;
               cnt_n   = '0;
            end else begin
               cnt_n   = cnt + 1'b1;
            end
         end
         ST_CLEAR: begin
            state_n = ST_IDLE;
            cnt_n   = '0;
`ifdef COMBO_CTRL_LOCKOUT_EN
            if (fail_cnt == FAIL_MAX) state_n = ST_LOCKOUT;
`endif
         end
`ifdef COMBO_CTRL_LOCKOUT_EN
         ST_LOCKOUT: begin
            if (cnt == LOCK_LAST) begin
               state_n = ST_IDLE;
               cnt_n   = '0;
               fail_n  = '0;
            end else begin
               cnt_n   = cnt + 1'b1;
            end
         end
`endif
         default: begin
            state_n = ST_CLEAR;
            cnt_n   = '0;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         fail_cnt  <= '0;
         owner     <= 1'b0;
         acc_q     <= 1'b0;
         core_code <= NO_KEY;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         fail_cnt  <= fail_n;
         owner     <= owner_n;
         acc_q     <= acc_n;
         core_code <= code_n;
      end
   end

   assign unlocked = (state == ST_UNLOCKED);
   assign core_rst = (state == ST_CLEAR);
`ifdef COMBO_CTRL_LOCKOUT_EN
   assign lockout         = (state == ST_LOCKOUT);
   assign core_master_rst = (state == ST_LOCKOUT) && (cnt == LOCK_LAST);
`else
   assign lockout         = 1'b0;
   assign core_master_rst = 1'b0;
`endif

endmodule

// File: tb/tb_combo_lock_ctrl.sv
// Scoreboard bench for combo_lock_ctrl: stimulus queues expected core-side events,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_combo_lock_ctrl;

   localparam int EV_CODE = 1, EV_CLEAR = 2, EV_UNLOCK = 3, EV_MRST = 4, EV_LOCK = 5;

   typedef struct {
      int kind;
      int val;
   } ev_t;

   ev_t  exp_q[$];
   int   checks = 0, errors = 0, cyc = 0;
   int   ulen = 0, llen = 0, lbad = 0, viol = 0, exp_fail = 0;
   bit   watch_a = 0, watch_b = 0;

   logic       CLK = 1'b0, RST = 1'b0;
   logic       a_valid, b_valid, a_ready, b_ready;
   logic [3:0] a_digit, b_digit, core_code;
   logic       core_rst, core_master_rst, unlocked, lockout, owner;
   logic [4:0] core_status;
   logic [1:0] fail_cnt;

   combo_lock_ctrl dut (
      .CLK             (CLK),
      .RST             (RST),
      .a_valid         (a_valid),
      .a_ready         (a_ready),
      .a_digit         (a_digit),
      .b_valid         (b_valid),
      .b_ready         (b_ready),
      .b_digit         (b_digit),
      .core_code       (core_code),
      .core_rst        (core_rst),
      .core_master_rst (core_master_rst),
      .core_status     (core_status),
      .unlocked        (unlocked),
      .lockout         (lockout),
      .owner           (owner),
      .fail_cnt        (fail_cnt)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic bound_fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s: DUT did not respond within the cycle bound", name);
   endtask

   task automatic expect_ev(input int kind, input int val);
      ev_t e;
      e.kind = kind;
      e.val  = val;
      exp_q.push_back(e);
   endtask

   task automatic got(input int kind, input int val);
      ev_t e;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL unexpected_event: got kind %0d value %0d, expected none", kind, val);
      end else begin
         e = exp_q.pop_front();
         check("event(kind*100000+value)", kind * 100000 + val, e.kind * 100000 + e.val);
      end
   endtask

   // Monitor: turns DUT outputs into events and compares them against the scoreboard.
   always @(negedge CLK) begin
      if (!RST) begin
         ulen = 0;
         llen = 0;
         lbad = 0;
      end else begin
         if (unlocked) ulen++;
         else if (ulen != 0) begin got(EV_UNLOCK, ulen); ulen = 0; end
         if (lockout) begin
            llen++;
            if (a_ready || b_ready) lbad++;
         end else if (llen != 0) begin
            got(EV_LOCK, llen + 10000 * lbad);
            llen = 0;
            lbad = 0;
         end
         if (core_code != 4'h0) got(EV_CODE, int'({owner, core_code}));
         if (core_rst) got(EV_CLEAR, int'(fail_cnt));
         if (core_master_rst) got(EV_MRST, int'(fail_cnt));
         if ((watch_a && a_ready) || (watch_b && b_ready)) viol++;
      end
   end

   // Offers one digit and returns 1 time unit after the accepting edge.
   task automatic send(input bit who, input logic [3:0] d);
      bit rdy;
      int n = 0;
      if (d != 4'h0) expect_ev(EV_CODE, int'(who) * 16 + int'(d));
      if (who) begin b_valid = 1'b1; b_digit = d; end
      else     begin a_valid = 1'b1; a_digit = d; end
      forever begin
         @(negedge CLK);
         rdy = who ? b_ready : a_ready;
         @(posedge CLK);
         if (rdy) break;
         n++;
         if (n > 200) begin bound_fail("send_ready"); break; end
      end
      #1;
      if (who) b_valid = 1'b0;
      else     a_valid = 1'b0;
   endtask

   // Core verdict in the first CHECK cycle; queues the outcome the controller must produce.
   task automatic verdict(input logic [4:0] st, input bit unlock);
      if (unlock) begin
         exp_fail = 0;
         expect_ev(EV_UNLOCK, 8);
         expect_ev(EV_CLEAR, 0);
      end else begin
         exp_fail = (exp_fail == 3) ? 3 : exp_fail + 1;
         expect_ev(EV_CLEAR, exp_fail);
      end
      core_status = st;
      @(posedge CLK);
      #1;
      core_status = 5'b0;
      if (unlock) check("unlock_latency", unlocked, 1'b1);
      else        check("fail_latency", core_rst, 1'b1);
   endtask

   initial begin
      int t0, t3, n;
      a_valid = 1'b0; b_valid = 1'b0; a_digit = 4'h0; b_digit = 4'h0; core_status = 5'b0;
      #12;
      check("rst_core_code", core_code, 4'h0);
      check("rst_core_rst", core_rst, 1'b0);
      check("rst_master_rst", core_master_rst, 1'b0);
      check("rst_unlocked", unlocked, 1'b0);
      check("rst_lockout", lockout, 1'b0);
      check("rst_owner", owner, 1'b0);
      check("rst_fail_cnt", fail_cnt, 2'd0);
      check("rst_a_ready", a_ready, 1'b0);
      check("rst_b_ready", b_ready, 1'b0);

      // Tie straight out of reset: A must win, B stays blocked.
      a_valid = 1'b1; a_digit = 4'd3; b_valid = 1'b1; b_digit = 4'd9;
      @(posedge CLK);
      #2 RST = 1'b1;
      watch_b = 1;
      send(0, 4'd3); t0 = cyc;
      send(0, 4'd7);
      send(0, 4'd1);
      send(0, 4'd5); t3 = cyc;
      check("digit_rate", t3 - t0, 6);
      a_valid = 1'b1; a_digit = 4'd2;
      verdict(5'b11010, 1);
      watch_b = 0;
      check("b_blocked", viol, 0);

      // Next IDLE is a tie again: B must win, A's held digit waits.
      send(1, 4'd9);
      watch_a = 1;
      send(1, 4'd8);
      send(1, 4'd7);
      send(1, 4'd6);
      verdict(5'b01101, 0);
      watch_a = 0;
      check("a_blocked", viol, 0);

      // A's held digit is taken now; this attempt times out in CHECK.
      send(0, 4'd2);
      send(0, 4'd6);
      send(0, 4'd6);
      send(0, 4'd6);
      exp_fail = 2;
      expect_ev(EV_CLEAR, 2);
      repeat (2) @(posedge CLK);
      #1 check("timeout_clear", core_rst, 1'b1);

      // Digit 0 as second digit aborts at once.
      send(0, 4'd4);
      exp_fail = 3;
      expect_ev(EV_CLEAR, 3);
      send(0, 4'd0);
      check("zero_abort_clear", core_rst, 1'b1);
      check("zero_abort_fail_cnt", fail_cnt, 2'd3);

`ifdef COMBO_CTRL_LOCKOUT_EN
      expect_ev(EV_MRST, 3);
      expect_ev(EV_LOCK, 1000);
      exp_fail = 0;
      @(posedge CLK);
      #1 check("lockout_on", lockout, 1'b1);
      a_valid = 1'b1; a_digit = 4'd1;
      n = 0;
      while (lockout && n < 1100) begin
         @(posedge CLK);
         #1 n++;
      end
      if (lockout) bound_fail("lockout_exit");
      check("lockout_cycles", n, 1000);
      check("fail_after_lockout", fail_cnt, 2'd0);
      send(0, 4'd1);
      send(0, 4'd2);
      send(0, 4'd3);
      send(0, 4'd4);
      verdict(5'b10000, 1);
`else
      for (int k = 0; k < 2; k++) begin
         send(0, 4'd5);
         send(0, 4'd5);
         send(0, 4'd5);
         send(0, 4'd5);
         verdict(5'b01000, 0);
      end
      check("fail_cnt_saturated", fail_cnt, 2'd3);
      check("no_lockout", lockout, 1'b0);
      send(0, 4'd1);
      send(0, 4'd2);
      send(0, 4'd3);
      send(0, 4'd4);
      verdict(5'b10000, 1);
`endif

      // Fail once, then reset in the middle of B's entry.
      send(0, 4'd6);
      send(0, 4'd6);
      send(0, 4'd6);
      send(0, 4'd6);
      verdict(5'b01000, 0);
      send(1, 4'd1);
      send(1, 4'd2);
      @(negedge CLK);
      #1 RST = 1'b0;
      #1;
      check("midrst_core_code", core_code, 4'h0);
      check("midrst_owner", owner, 1'b0);
      check("midrst_fail_cnt", fail_cnt, 2'd0);
      check("midrst_core_rst", core_rst, 1'b0);
      check("midrst_b_ready", b_ready, 1'b0);
      exp_fail = 0;
      repeat (2) @(posedge CLK);
      #2 RST = 1'b1;

      // Two digits after release must not reach CHECK.
      send(0, 4'd3);
      send(0, 4'd4);
      core_status = 5'b10000;
      repeat (4) @(posedge CLK);
      #1 core_status = 5'b0;
      check("no_early_check", unlocked, 1'b0);
      send(0, 4'd5);
      send(0, 4'd6);
      verdict(5'b10000, 1);

      repeat (20) @(posedge CLK);
      check("pending_events", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

endmodule
